// File: rtl/timer_cnt_ctrl_pkg.sv
// Shared timer definitions: counting modes, sequencer states and default counter width.
package timer_cnt_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    TMR_FREE     = 2'd0,
    TMR_PERIODIC = 2'd1,
    TMR_ONESHOT  = 2'd2
  } tmr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } tmr_state_e;

endpackage

// File: rtl/timer_cnt_ctrl.sv
// Main-counter sequencer: mode FSM, prescaler-gated counter, compare match,
// sticky interrupt flag and debug-halt handshake.
module timer_cnt_ctrl
  import timer_cnt_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             tick,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             cnt_wr,
  input  logic [CNT_W-1:0] cnt_wdata,
  input  logic             int_en,
  input  logic             int_clr,
  input  logic             halt_req,
  output logic [CNT_W-1:0] cnt_val,
  output logic             int_flag,
  output logic             irq,
  output logic             halt_ack,
  output logic             running
);

  tmr_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             flag_reg;
  logic             run_tick;
  logic             match_evt;

  // A software write suppresses both counting and match evaluation that cycle.
  assign run_tick  = (state_reg == ST_RUN) && tick && !cnt_wr;
  assign match_evt = run_tick && (cnt_reg == cmp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (timer_en) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Halt request wins over a coincident one-shot completion.
        if (!timer_en)                               state_next = ST_IDLE;
        else if (halt_req)                           state_next = ST_HALT;
        else if (match_evt && (mode == TMR_ONESHOT)) state_next = ST_DONE;
      end
      ST_HALT: begin
        if (!timer_en)     state_next = ST_IDLE;
        else if (!halt_req) state_next = ST_RUN;
      end
      ST_DONE: begin
        if (!timer_en)   state_next = ST_IDLE;
        else if (cnt_wr) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else begin
      if (cnt_wr) begin
        cnt_reg <= cnt_wdata;
      end else if (run_tick) begin
        if (match_evt && (mode == TMR_PERIODIC)) begin
          cnt_reg <= '0;
        end else if (match_evt && (mode == TMR_ONESHOT)) begin
          cnt_reg <= cnt_reg;
        end else begin
          // Free-run and the reserved mode both wrap naturally.
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      if (match_evt) begin
        flag_reg <= 1'b1;
      end else if (int_clr) begin
        flag_reg <= 1'b0;
      end
    end
  end

  assign cnt_val  = cnt_reg;
  assign int_flag = flag_reg;
  assign irq      = flag_reg & int_en;
  assign halt_ack = (state_reg == ST_HALT);
  assign running  = (state_reg == ST_RUN);

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Self-checking bench for timer_cnt_ctrl: vector table, directed corner sequences,
// then randomized traffic against a behavioural model.
module tb_timer_cnt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        timer_en = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] cmp_val = '0;
  logic        cnt_wr = 1'b0;
  logic [31:0] cnt_wdata = '0;
  logic        int_en = 1'b0;
  logic        int_clr = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] cnt_val;
  logic        int_flag, irq, halt_ack, running;

  int compared = 0;
  int mismatched = 0;

  timer_cnt_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .timer_en(timer_en), .tick(tick), .mode(mode),
    .cmp_val(cmp_val), .cnt_wr(cnt_wr), .cnt_wdata(cnt_wdata), .int_en(int_en),
    .int_clr(int_clr), .halt_req(halt_req), .cnt_val(cnt_val), .int_flag(int_flag),
    .irq(irq), .halt_ack(halt_ack), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, tk;
    logic [1:0]  md;
    logic [31:0] cmp;
    logic        wr;
    logic [31:0] wd;
    logic        ie, clr, hr;
    logic [31:0] e_cnt;
    logic        e_flag, e_irq, e_run, e_hack;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_cnt, input logic e_flag,
                         input logic e_irq, input logic e_run, input logic e_hack);
    chk({tag, "_cnt"}, cnt_val, e_cnt);
    chk({tag, "_flag"}, 32'(int_flag), 32'(e_flag));
    chk({tag, "_irq"}, 32'(irq), 32'(e_irq));
    chk({tag, "_run"}, 32'(running), 32'(e_run));
    chk({tag, "_hack"}, 32'(halt_ack), 32'(e_hack));
  endtask

  // One clock; single-cycle pulses drop right after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0; cnt_wr = 1'b0; int_clr = 1'b0;
  endtask

  function automatic void add(input logic tk, input logic [1:0] md, input logic [31:0] cmp,
                              input logic wr, input logic [31:0] wd, input logic clr,
                              input logic [31:0] e_cnt, input logic e_flag);
    vec_t v;
    v.en = 1'b1; v.tk = tk; v.md = md; v.cmp = cmp; v.wr = wr; v.wd = wd;
    v.ie = 1'b1; v.clr = clr; v.hr = 1'b0;
    v.e_cnt = e_cnt; v.e_flag = e_flag; v.e_irq = e_flag; v.e_run = 1'b1; v.e_hack = 1'b0;
    vecs.push_back(v);
  endfunction

  // Behavioural model: phase flags rather than a state register.
  logic [31:0] m_cnt;
  logic        m_flag, m_idle, m_halted, m_finished;

  function automatic void model_step(input logic en, tk, input logic [1:0] md,
                                     input logic [31:0] cmp, input logic wr,
                                     input logic [31:0] wd, input logic clr, hr);
    logic counting, ev;
    counting = !m_idle && !m_halted && !m_finished;
    ev = counting && tk && !wr && (m_cnt == cmp);
    if (wr) m_cnt = wd;
    else if (counting && tk) begin
      if (ev && md == 2'd1)      m_cnt = 32'd0;
      else if (!(ev && md == 2'd2)) m_cnt = m_cnt + 32'd1;
    end
    if (ev) m_flag = 1'b1;
    else if (clr) m_flag = 1'b0;
    if (m_idle) begin
      if (en) m_idle = 1'b0;
    end else if (!en) begin
      m_idle = 1'b1; m_halted = 1'b0; m_finished = 1'b0;
    end else if (m_halted) begin
      if (!hr) m_halted = 1'b0;
    end else if (m_finished) begin
      if (wr) m_finished = 1'b0;
    end else if (hr) begin
      m_halted = 1'b1;   // halt taken ahead of a coincident one-shot completion
    end else if (ev && md == 2'd2) begin
      m_finished = 1'b1;
    end
  endfunction

  initial begin
    // ---------- reset ----------
    #12;
    chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // ---------- table: free-run then periodic ----------
    add(1'b0, 2'd0, 32'd5, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int k = 1; k <= 8; k++) add(1'b1, 2'd0, 32'd5, 1'b0, 32'd0, 1'b0, 32'(k), k >= 6);
    add(1'b0, 2'd0, 32'd5, 1'b0, 32'd0, 1'b0, 32'd8, 1'b1);
    add(1'b0, 2'd0, 32'd5, 1'b0, 32'd0, 1'b1, 32'd8, 1'b0);
    add(1'b0, 2'd1, 32'd3, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int k = 1; k <= 12; k++)
      add(1'b1, 2'd1, 32'd3, 1'b0, 32'd0, (k % 4) == 1 && k > 1, 32'(k % 4), (k % 4) == 0);

    for (int i = 0; i < vecs.size(); i++) begin
      timer_en = vecs[i].en; tick = vecs[i].tk; mode = vecs[i].md; cmp_val = vecs[i].cmp;
      cnt_wr = vecs[i].wr; cnt_wdata = vecs[i].wd; int_en = vecs[i].ie;
      int_clr = vecs[i].clr; halt_req = vecs[i].hr;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_flag, vecs[i].e_irq,
              vecs[i].e_run, vecs[i].e_hack);
    end
    $display("table: %0d vectors applied", vecs.size());

    // ---------- one-shot ----------
    mode = 2'd2; cmp_val = 32'd2; cnt_wr = 1'b1; cnt_wdata = 32'd0; int_clr = 1'b1;
    step();
    chk_all("os_load", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick = 1'b1;
      step();
      chk_all($sformatf("os_tick%0d", k), (k >= 2) ? 32'd2 : 32'(k), k >= 3, k >= 3, k < 3, 1'b0);
    end
    cnt_wr = 1'b1; cnt_wdata = 32'd0;
    step();
    chk_all("os_restart", 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    $display("one-shot sequence done");

    // ---------- wrap and priority ----------
    mode = 2'd0; cmp_val = 32'd5; int_clr = 1'b1;
    step();
    cnt_wr = 1'b1; cnt_wdata = 32'hFFFF_FFFF;
    step();
    chk("wrap_load", cnt_val, 32'hFFFF_FFFF);
    tick = 1'b1;
    step();
    chk("wrap_tick", cnt_val, 32'd0);
    cnt_wr = 1'b1; cnt_wdata = 32'd7; tick = 1'b1;
    step();
    chk("wr_over_tick", cnt_val, 32'd7);
    chk("wr_no_match", 32'(int_flag), 32'd0);
    cmp_val = 32'd7; tick = 1'b1; int_clr = 1'b1;
    step();
    chk("set_over_clr", 32'(int_flag), 32'd1);
    chk("set_over_clr_cnt", cnt_val, 32'd8);
    $display("wrap/priority sequence done");

    // ---------- halt ----------
    halt_req = 1'b1;
    step();
    chk_all("halt_enter", 32'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick = 1'b1;
      step();
    end
    chk_all("halt_hold", 32'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    halt_req = 1'b0;
    step();
    chk_all("halt_exit", 32'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    tick = 1'b1;
    step();
    chk("halt_resume", cnt_val, 32'd9);
    $display("halt sequence done");

    // ---------- asynchronous reset mid-count ----------
    tick = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    $display("async reset sequence done");

    // ---------- randomized against model ----------
    m_cnt = 32'd0; m_flag = 1'b0; m_idle = 1'b1; m_halted = 1'b0; m_finished = 1'b0;
    timer_en = 1'b0; halt_req = 1'b0; cmp_val = 32'd3; mode = 2'd0;
    for (int n = 0; n < 2000; n++) begin
      timer_en = ($urandom_range(0, 99) >= 3);
      tick = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) cmp_val = $urandom_range(0, 12);
      cnt_wr = ($urandom_range(0, 19) == 0);
      cnt_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                              : 32'($urandom_range(0, 10));
      int_en = $urandom_range(0, 1);
      int_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      model_step(timer_en, tick, mode, cmp_val, cnt_wr, cnt_wdata, int_clr, halt_req);
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", n), m_cnt, m_flag, m_flag & int_en,
              !m_idle && !m_halted && !m_finished, !m_idle && m_halted);
      tick = 1'b0; cnt_wr = 1'b0; int_clr = 1'b0;
    end
    $display("random: 2000 cycles applied");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timer_cnt_ctrl.md
# timer_cnt_ctrl

Timer main-counter sequencer for the APB timer peripheral. It owns the CNT_W-bit main counter, which advances only on prescaler ticks (`tick`, the prescaler's count-enable output), and runs a mode state machine (free-run, periodic, one-shot). It also handles compare-match detection, the sticky interrupt flag, and debug-halt handshaking. The APB register block drives its configuration and software-write pulses.

## Interface
- CNT_W, 32, width of main counter, load and compare values (≥ 2)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- timer_en  in  1  global timer enable (level)
- tick  in  1  prescaler count-enable pulse, one clk wide
- mode  in  2  0 free-run, 1 periodic, 2 one-shot, 3 reserved (treated as free-run)
- cmp_val  in  CNT_W  compare value
- cnt_wr  in  1  software write pulse to counter
- cnt_wdata  in  CNT_W  value loaded on cnt_wr
- int_en  in  1  interrupt enable
- int_clr  in  1  write-1-to-clear pulse for int_flag
- halt_req  in  1  debug halt request (level)
- cnt_val  out  CNT_W  current counter value
- int_flag  out  1  sticky match flag
- irq  out  1  int_flag & int_en (combinational from registered flag)
- halt_ack  out  1  high while in HALT
- running  out  1  high while in RUN

## Operation
- States are IDLE, RUN, HALT and DONE. Reset state is IDLE.
- Reset values: cnt_val = 0, int_flag = 0, irq = 0, halt_ack = 0, running = 0.
- State transitions:
  - IDLE→RUN when timer_en = 1.
  - RUN/HALT/DONE→IDLE when timer_en = 0. This exit has priority over every other transition.
  - RUN→HALT when halt_req = 1. HALT→RUN when halt_req = 0.
  - RUN→DONE on a match event in one-shot mode.
  - DONE→RUN on cnt_wr with timer_en = 1.
- cnt_val and int_flag are held (not cleared) in IDLE, HALT and DONE. Ticks are ignored outside RUN.
- Match event: state = RUN, tick = 1 and cnt_val == cmp_val, all in the same cycle. The counter update on an event depends on mode:
  - Free-run: cnt_val + 1, wrapping from 2^CNT_W−1 to 0.
  - Periodic: cnt_val ← 0.
  - One-shot: cnt_val holds and the state moves to DONE.
- Non-event tick in RUN: cnt_val + 1, wrapping modulo 2^CNT_W.
- cnt_wr loads cnt_wdata in any state and has priority over a tick in the same cycle. No match event is evaluated in a cnt_wr cycle.
- int_flag is set by a match event and cleared by int_clr. If both occur in the same cycle, set wins.
- int_flag sets regardless of int_en. Only irq is gated by int_en.
- cmp_val = 0 in periodic mode: every tick is an event and cnt_val stays at 0.
- A mode change takes effect on the next tick. No state change results from it.

## Timing
- cnt_val, int_flag and the state update on the clk edge that samples the tick, cnt_wr or int_clr. They are visible one cycle after the input pulse.
- irq follows int_flag combinationally. It therefore rises one cycle after the event tick.
- halt_ack rises one cycle after halt_req rises (a RUN→HALT registered transition) and falls one cycle after halt_req falls.
- Asynchronous reset mid-count: all outputs return to their reset values immediately. Operation restarts in IDLE at the next edge with rst_n high.
- Back-to-back ticks (tick high on consecutive cycles) must be handled: one increment per cycle.

## Structure
- Shared timer package holds:
  - the mode enum (TMR_FREE, TMR_PERIODIC, TMR_ONESHOT),
  - the state enum (ST_IDLE, ST_RUN, ST_HALT, ST_DONE),
  - the CNT_W default constant.
- Single module, no sub-modules: one state register, one next-state block, and one counter/flag sequential block.

## Test plan
- Free-run: cmp = 5, cnt_wr with 0, timer_en = 1, 8 ticks. Required: cnt_val reaches 8, int_flag sets the cycle after the 6th tick, and with int_en = 1 irq = 1.
- Periodic: cmp = 3, 12 ticks. Required: cnt_val sequence 0,1,2,3,0,…. int_clr each period; int_flag re-sets after ticks 4, 8 and 12.
- One-shot: cmp = 2, 5 ticks. Required: state DONE after tick 3, cnt_val holds at 2, running = 0. A later cnt_wr of 0 returns running to 1.
- Wrap and priority:
  - cnt_wr of FFFF_FFFF followed by a tick gives cnt_val = 0.
  - cnt_wr of 7 and a tick in the same cycle give cnt_val = 7.
  - int_clr coincident with a match leaves int_flag = 1.
- Halt and reset:
  - halt_req during RUN gives halt_ack one cycle later, and 4 ticks leave cnt_val unchanged. Releasing halt_req resumes counting.
  - rst_n asserted mid-count gives cnt_val = 0 and int_flag = 0 immediately.
